// File: rtl/fold_lane_arbiter.sv
// Round-robin owner of a shared 16->8 XOR fold lane, with a registered response slot.
// Define FOLD_ACC_EN for packet-digest mode (one XOR-accumulated response per packet).
module fold_lane_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_last,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [15:0]          fu_a,
    output logic [15:0]          fu_b,
    input  logic [7:0]           fu_aa,
    input  logic [7:0]           fu_bb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_aa,
    output logic [7:0]           rsp_bb
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] rr_ptr_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [7:0]     rsp_aa_q;
    logic [7:0]     rsp_bb_q;
`ifdef FOLD_ACC_EN
    logic [7:0]     acc_aa_q;
    logic [7:0]     acc_bb_q;
`endif

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] rr_ptr_d;
    logic           ow_valid;
    logic           ow_last;
    logic [15:0]    ow_a;
    logic [15:0]    ow_b;
    logic           slot_free;
    logic           owner_ready;
    logic           beat_fire;
    logic           rsp_load;
    logic [7:0]     rsp_aa_d;
    logic [7:0]     rsp_bb_d;

    // Two passes: first requesters at/after rr_ptr, then wrap to the low indices.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && (k >= int'(rr_ptr_q)) && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
            end
        end
        if (int'(grant_idx) == NREQ - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_idx + IDW'(1);
        end
    end

    always_comb begin
        ow_valid = 1'b0;
        ow_last  = 1'b0;
        ow_a     = 16'h0;
        ow_b     = 16'h0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == IDW'(k)) begin
                ow_valid = req_valid[k];
                ow_last  = req_last[k];
                ow_a     = req_a[16*k +: 16];
                ow_b     = req_b[16*k +: 16];
            end
        end
    end

    // The slot may be refilled in the same cycle its current entry drains.
    assign slot_free = !rsp_valid_q || rsp_ready;

`ifdef FOLD_ACC_EN
    assign owner_ready = (state_q == OWN) && (!ow_last || slot_free);
    assign beat_fire   = owner_ready && ow_valid;
    assign rsp_load    = beat_fire && ow_last;
    assign rsp_aa_d    = acc_aa_q ^ fu_aa;
    assign rsp_bb_d    = acc_bb_q ^ fu_bb;
`else
    assign owner_ready = (state_q == OWN) && slot_free;
    assign beat_fire   = owner_ready && ow_valid;
    assign rsp_load    = beat_fire;
    assign rsp_aa_d    = fu_aa;
    assign rsp_bb_d    = fu_bb;
`endif

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_ready && (owner_q == IDW'(k))) begin
                req_ready[k] = 1'b1;
            end
        end
    end

    assign fu_a      = (state_q == OWN) ? ow_a : 16'h0;
    assign fu_b      = (state_q == OWN) ? ow_b : 16'h0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_aa    = rsp_aa_q;
    assign rsp_bb    = rsp_bb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_aa_q    <= 8'h0;
            rsp_bb_q    <= 8'h0;
`ifdef FOLD_ACC_EN
            acc_aa_q    <= 8'h0;
            acc_bb_q    <= 8'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        owner_q  <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= OWN;
                    end
                end
                OWN: begin
                    if (beat_fire && ow_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (rsp_load) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= owner_q;
                rsp_aa_q    <= rsp_aa_d;
                rsp_bb_q    <= rsp_bb_d;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

`ifdef FOLD_ACC_EN
            if (beat_fire) begin
                if (ow_last) begin
                    acc_aa_q <= 8'h0;
                    acc_bb_q <= 8'h0;
                end else begin
                    acc_aa_q <= acc_aa_q ^ fu_aa;
                    acc_bb_q <= acc_bb_q ^ fu_bb;
                end
            end
`endif
        end
    end

endmodule
